// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the start-acceptance rule used by the controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A new request can only be taken while no operation is in flight.
  function automatic logic can_accept(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requesting datapath (master) and the
// serial adder controller (slave).
interface serial_adder_ctrl_if #(
  parameter int NUM_BITS = 8
);

  // Handshake: master raises start with a/b/carry_in valid; the request is
  // taken on a rising edge where the controller is not busy (IDLE or DONE).
  // Operands are captured on that edge only. done pulses for one cycle when
  // sum/carry_out have been updated; results hold until the next completion.
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );

endinterface

// File: rtl/serial_adder_ctrl_adder_1bit.sv
// Single-bit full adder: the one shared arithmetic resource the serial
// controller sequences over the operand bits.
module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller: feeds one operand bit per clock, LSB first,
// through a single full adder and assembles the sum in a shift register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  serial_adder_ctrl_if.slave  bus,
  output state_t              state
);

  localparam int CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] a_reg;
  logic [NUM_BITS-1:0] b_reg;
  logic                c_reg;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_BITS-1:0] shift_sum;
  logic [NUM_BITS-1:0] sum_q;
  logic                carry_q;
  logic                busy_q;
  logic                done_q;

  state_t              next_state;
  logic [NUM_BITS-1:0] a_next;
  logic [NUM_BITS-1:0] b_next;
  logic                c_next;
  logic [CNT_W-1:0]    cnt_next;
  logic [NUM_BITS-1:0] shift_next;
  logic [NUM_BITS-1:0] sum_next;
  logic                carry_next;

  logic                add_s;
  logic                add_c;

  adder_1bit u_adder (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (c_reg),
    .s    (add_s),
    .cout (add_c)
  );

  always_comb begin
    next_state = state;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    cnt_next   = cnt;
    shift_next = shift_sum;
    sum_next   = sum_q;
    carry_next = carry_q;

    case (state)
      IDLE, DONE: begin
        if (can_accept(state) && bus.start) begin
          a_next     = bus.a;
          b_next     = bus.b;
          c_next     = bus.carry_in;
          cnt_next   = '0;
          shift_next = '0;
          next_state = ADD;
        end else begin
          next_state = IDLE;
        end
      end
      ADD: begin
        a_next     = a_reg >> 1;
        b_next     = b_reg >> 1;
        c_next     = add_c;
        cnt_next   = cnt + 1'b1;
        shift_next = {add_s, shift_sum[NUM_BITS-1:1]};
        // Last bit: publish the fully shifted word, not the stale register.
        if (cnt == CNT_LAST) begin
          sum_next   = {add_s, shift_sum[NUM_BITS-1:1]};
          carry_next = add_c;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      shift_sum <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= next_state;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      cnt       <= cnt_next;
      shift_sum <= shift_next;
      sum_q     <= sum_next;
      carry_q   <= carry_next;
      busy_q    <= (next_state == ADD);
      done_q    <= (next_state == DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;

endmodule
